// File: rtl/sa_scan_ctrl_if.sv
// rtl/sa_scan_ctrl_if.sv - host-side handshake of the scan chain controller
interface sa_scan_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 start;
  logic                 capture_en;
  logic [CHAIN_LEN-1:0] pat_in;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] resp_out;

  modport master (output start, capture_en, pat_in, input busy, done, resp_out);
  modport slave  (input start, capture_en, pat_in, output busy, done, resp_out);
endinterface

// File: rtl/sa_scan_ctrl.sv
// rtl/sa_scan_ctrl.sv - serial load / optional capture / unload driver for one scan chain
module sa_scan_ctrl #(
  parameter  int CHAIN_LEN = 16,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic          CP,
  input  logic          RN,
  sa_scan_ctrl_if.slave host,
  output logic          SE,
  output logic          SI,
  input  logic          SO
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_reg;
  logic [CHAIN_LEN-1:0] resp_sh;
  logic                 cap_reg;
  logic                 last;
  logic [CHAIN_LEN-1:0] resp_next;

  assign last      = (cnt == CNT_W'(CHAIN_LEN - 1));
  assign resp_next = {resp_sh[CHAIN_LEN-2:0], SO};

  // Outputs are registered alongside the state so they never see the inputs combinationally.
  always_ff @(posedge CP) begin
    if (!RN) begin
      state         <= S_IDLE;
      cnt           <= '0;
      pat_reg       <= '0;
      resp_sh       <= '0;
      cap_reg       <= 1'b0;
      host.resp_out <= '0;
      host.busy     <= 1'b0;
      host.done     <= 1'b0;
      SE            <= 1'b0;
      SI            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.start) begin
            pat_reg   <= host.pat_in;
            cap_reg   <= host.capture_en;
            cnt       <= '0;
            host.busy <= 1'b1;
            SE        <= 1'b1;
            SI        <= host.pat_in[CHAIN_LEN-1];
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          pat_reg <= pat_reg << 1;
          if (last) begin
            cnt   <= '0;
            SI    <= 1'b0;
            SE    <= !cap_reg;
            state <= cap_reg ? S_CAPT : S_UNLOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
            SI  <= pat_reg[CHAIN_LEN-2];
          end
        end
        S_CAPT: begin
          cnt   <= '0;
          SE    <= 1'b1;
          SI    <= 1'b0;
          state <= S_UNLOAD;
        end
        S_UNLOAD: begin
          // First sample is the tail flop, so the word ends up in chain order.
          resp_sh <= resp_next;
          if (last) begin
            cnt           <= '0;
            host.resp_out <= resp_next;
            host.done     <= 1'b1;
            SE            <= 1'b0;
            state         <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          host.done <= 1'b0;
          host.busy <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          host.done <= 1'b0;
          host.busy <= 1'b0;
          SE        <= 1'b0;
          SI        <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule
